// File: rtl/tl_log_replayer_if.sv
// Record stream bundle for the TileLink log replayer.
// One instance per direction: master drives valid and fields, slave drives ready.
interface tl_log_replayer_if #(
    parameter int STAMP_W = 64
);
    logic               valid;
    logic               ready;
    logic [7:0]         channel;
    logic [7:0]         opcode;
    logic [7:0]         param;
    logic [7:0]         source;
    logic [7:0]         sink;
    logic [63:0]        address;
    logic [63:0]        data_0;
    logic [63:0]        data_1;
    logic [63:0]        data_2;
    logic [63:0]        data_3;
    logic [STAMP_W-1:0] stamp;

    modport master (
        output valid, channel, opcode, param, source, sink,
        output address, data_0, data_1, data_2, data_3, stamp,
        input  ready
    );

    modport slave (
        input  valid, channel, opcode, param, source, sink,
        input  address, data_0, data_1, data_2, data_3, stamp,
        output ready
    );
endinterface

// File: rtl/tl_log_replayer.sv
// Buffers logged TileLink records and releases each one on the output
// stream once the local cycle counter reaches its stamp.
module tl_log_replayer #(
    parameter int DEPTH   = 4,
    parameter int STAMP_W = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [STAMP_W-1:0] start_stamp,
    input  logic               stop,
    input  logic               ungated,
    tl_log_replayer_if.slave   in_if,
    tl_log_replayer_if.master  out_if,
    output logic [31:0]        late_count,
    output logic               order_err,
    output logic               busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    typedef struct packed {
        logic [7:0]         channel;
        logic [7:0]         opcode;
        logic [7:0]         param;
        logic [7:0]         source;
        logic [7:0]         sink;
        logic [63:0]        address;
        logic [63:0]        data_0;
        logic [63:0]        data_1;
        logic [63:0]        data_2;
        logic [63:0]        data_3;
        logic [STAMP_W-1:0] stamp;
    } rec_t;

    state_t             state_q, state_d;
    logic [STAMP_W-1:0] now_q, now_d;
    logic [STAMP_W-1:0] last_q, last_d;
    logic [PW-1:0]      wr_q, wr_d;
    logic [PW-1:0]      rd_q, rd_d;
    rec_t               mem_q [DEPTH];
    rec_t               mem_d [DEPTH];
    logic [31:0]        late_q, late_d;
    logic               err_q, err_d;

    rec_t in_rec;
    rec_t head;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic eligible;

    assign in_rec = {in_if.channel, in_if.opcode, in_if.param,
                     in_if.source, in_if.sink, in_if.address,
                     in_if.data_0, in_if.data_1, in_if.data_2,
                     in_if.data_3, in_if.stamp};

    assign head  = mem_q[rd_q[AW-1:0]];
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty = (wr_q == rd_q);
    assign push  = in_if.valid && !full;

    // Unsigned compare: a wrapped counter is deliberately not corrected.
    assign eligible = ungated || (now_q >= head.stamp);

    assign in_if.ready    = !full;
    assign out_if.valid   = (state_q != IDLE) && !empty && eligible;
    assign pop            = out_if.valid && out_if.ready;

    assign out_if.channel = head.channel;
    assign out_if.opcode  = head.opcode;
    assign out_if.param   = head.param;
    assign out_if.source  = head.source;
    assign out_if.sink    = head.sink;
    assign out_if.address = head.address;
    assign out_if.data_0  = head.data_0;
    assign out_if.data_1  = head.data_1;
    assign out_if.data_2  = head.data_2;
    assign out_if.data_3  = head.data_3;
    assign out_if.stamp   = head.stamp;

    assign late_count = late_q;
    assign order_err  = err_q;
    assign busy       = (state_q != IDLE) || !empty;

    // Next-state: run control, FIFO pointers/storage and statistics.
    always_comb begin
        state_d = state_q;
        now_d   = now_q;
        last_d  = last_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        mem_d   = mem_q;
        late_d  = late_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    now_d   = start_stamp;
                end
            end
            RUN: begin
                now_d = now_q + STAMP_W'(1);
                if (stop) begin
                    state_d = (out_if.valid && !out_if.ready) ? STOPPING : IDLE;
                end
            end
            STOPPING: begin
                now_d = now_q + STAMP_W'(1);
                if (pop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            mem_d[wr_q[AW-1:0]] = in_rec;
            wr_d   = wr_q + PW'(1);
            last_d = in_rec.stamp;
            if (in_rec.stamp < last_q) begin
                err_d = 1'b1;
            end
        end

        if (pop) begin
            rd_d = rd_q + PW'(1);
            if (!ungated && (now_q > head.stamp) && (late_q != '1)) begin
                late_d = late_q + 32'd1;
            end
        end
    end

    // State registers; reset also discards any buffered records.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            now_q   <= '0;
            last_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            late_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            now_q   <= now_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            late_q  <= late_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end
endmodule

// File: doc/tl_log_replayer.md
# tl_log_replayer

Replays logged TileLink transaction records onto a cycle-timed output stream: the reader-side counterpart of the per-channel TileLink log writer. Records arrive in the same field layout the writer emits (channel, opcode, param, source, sink, address, four data words, stamp). Each record is buffered and released on a valid/ready output once a local cycle counter reaches its stamp. It sits between a record source (DPI reader or trace memory) and a TileLink stimulus driver in the HuanCun test environment.

## Interface
- DEPTH, 4: record FIFO entries; power of two, ≥2.
- STAMP_W, 64: cycle counter and stamp width.
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; in IDLE, loads `now` with start_stamp and enters RUN.
- start_stamp  in  STAMP_W  initial `now` value.
- stop  in  1  pulse; requests return to IDLE.
- ungated  in  1  1 = ignore stamps and release as soon as the head is valid.
- in_valid / in_ready  in / out  1  record input handshake.
- in_channel, in_opcode, in_param, in_source, in_sink  in  8 each  record fields.
- in_address, in_data_0..in_data_3  in  64 each  record fields.
- in_stamp  in  STAMP_W  target release cycle.
- out_valid / out_ready  out / in  1  record output handshake.
- out_channel … out_stamp  out  same widths as in_*  head record fields.
- late_count  out  32  records released after their stamp; saturating.
- order_err  out  1  sticky; an accepted stamp was smaller than the previous accepted stamp.
- busy  out  1  state ≠ IDLE or FIFO non-empty.

## Operation
- States: IDLE, RUN, STOPPING.
  - IDLE: `now` frozen. start → RUN, with `now` ← start_stamp.
  - RUN: `now` += 1 every cycle, modulo 2^STAMP_W. No wrap correction; comparisons are unsigned.
  - RUN + stop: if out_valid && !out_ready, go to STOPPING; else go to IDLE.
  - STOPPING: `now` keeps counting. On the output handshake, go to IDLE.
  - start and stop in the same cycle: stop wins. start outside IDLE is ignored.
- FIFO:
  - in_ready = !full. Push on in_valid && in_ready.
  - No push while full, even if a pop happens in the same cycle.
  - Pointers are log2(DEPTH)+1 bits. full/empty come from the MSB difference.
  - Push and pop in the same cycle (not full, not empty) leaves the count unchanged.
  - The FIFO fills and drains in all states. In IDLE, the head is simply not released.
- Release:
  - eligible = (ungated || now ≥ head.stamp).
  - out_valid = state ≠ IDLE && !empty && eligible.
  - out_* fields are taken combinationally from the head entry.
- Stability: once out_valid is high it stays high, with fields unchanged, until out_ready. This holds because `now` is monotonic and the head changes only on a pop.
- late_count: on each handshake with !ungated && now > head.stamp, add 1, saturating at 0xFFFFFFFF.
- order_err: on a push with in_stamp < last_stamp, set and hold until reset. last_stamp updates on every push and resets to 0.

## Timing
- Reset values:
  - state IDLE, `now` = 0, FIFO empty, last_stamp = 0.
  - in_ready = 1, out_valid = 0, late_count = 0, order_err = 0, busy = 0.
  - out_* fields = 0 (registers cleared).
- Input-to-output latency: a record pushed in cycle t becomes the head no earlier than t+1.
  - If it is eligible in t+1, out_valid rises in t+1.
  - Minimum latency is 1 cycle; there is no combinational path from in_* to out_*.
- Counter timing: start in cycle t gives `now` = start_stamp in cycle t+1, start_stamp+1 in t+2, and so on.
- Stamp release: a head with stamp S (S ≥ start_stamp, not ungated) raises out_valid in the first cycle where the registered `now` = S.
- Throughput: with out_ready held high, one record per cycle.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Records held in the FIFO are discarded.

## Test plan
- start with start_stamp = 100; push stamps 102 and 105; out_ready = 1 → handshakes exactly when `now` = 102 and `now` = 105; late_count = 0.
- Push stamp 10 while IDLE; start at cycle 0 with start_stamp = 20 → released at `now` = 20; late_count = 1.
- ungated = 1; push 4 records back to back; out_ready = 1 → 4 consecutive output beats starting 1 cycle after the first push; in_ready stays 1.
- out_ready = 0; push DEPTH+1 records → in_ready falls after DEPTH pushes. out_valid and fields stay stable for 10 cycles. Raising out_ready drains all records in order.
- Push stamps 50 then 40 → order_err = 1 and stays 1 after both records drain.
- out_valid high with out_ready = 0, then stop → state STOPPING. After one handshake, state = IDLE, out_valid = 0, busy = 1 while records remain.
